// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Target end of the core's memory-stage load/store interface. Accepts one
// word-aligned request at a time, waits WAIT_CYCLES clocks, performs the
// access and presents a response until the requester takes it.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_addr            byte address (must be word aligned and in range)
//   req_wdata, req_be   store data and per-byte-lane write enables
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           load data (zero for stores and errors)
//   rsp_err             misaligned or out-of-range request
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DAT_WIDTH-1:0]  req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DAT_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err
);

    localparam int                    IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]            WAIT_INIT   = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    req_write_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic [DAT_WIDTH-1:0]    req_wdata_r;
    logic [3:0]              req_be_r;
    logic [DAT_WIDTH-1:0]    rsp_rdata_r;
    logic                    rsp_err_r;

    logic [DAT_WIDTH-1:0]    mem [DEPTH_WORDS];

    logic                    acc_go_s;
    logic                    acc_write_s;
    logic [ADDR_WIDTH-1:0]   acc_addr_s;
    logic [DAT_WIDTH-1:0]    acc_wdata_s;
    logic [3:0]              acc_be_s;
    logic                    acc_err_s;
    logic [IDX_W-1:0]        acc_idx_s;
    logic [DAT_WIDTH-1:0]    acc_rdata_s;
    logic                    mem_we_s;

    // A request is illegal when it is not word aligned or its word index
    // lies beyond the end of the array.
    function automatic logic access_error(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);
    endfunction

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Select the request that is accessed on this edge: straight from the
    // inputs when there are no wait states, otherwise the latched request.
    always_comb begin
        acc_go_s    = 1'b0;
        acc_write_s = req_write_r;
        acc_addr_s  = req_addr_r;
        acc_wdata_s = req_wdata_r;
        acc_be_s    = req_be_r;
        case (state_r)
            ST_IDLE: begin
                acc_write_s = req_write;
                acc_addr_s  = req_addr;
                acc_wdata_s = req_wdata;
                acc_be_s    = req_be;
                if (req_valid && (WAIT_INIT == 4'd0)) begin
                    acc_go_s = 1'b1;
                end else begin
                    acc_go_s = 1'b0;
                end
            end
            ST_WAIT: begin
                // The decrement that takes the counter to zero is the access edge.
                if (cnt_r <= 4'd1) begin
                    acc_go_s = 1'b1;
                end else begin
                    acc_go_s = 1'b0;
                end
            end
            default: begin
                acc_go_s = 1'b0;
            end
        endcase
    end

    // Decode the selected request and fetch load data.
    always_comb begin
        acc_err_s = access_error(acc_addr_s);
        acc_idx_s = acc_addr_s[IDX_W+1:2];
        mem_we_s  = acc_go_s && acc_write_s && !acc_err_s && !rst;
        if (!acc_write_s && !acc_err_s) begin
            acc_rdata_s = mem[acc_idx_s];
        end else begin
            acc_rdata_s = {DAT_WIDTH{1'b0}};
        end
    end

    // Byte-lane store into the (unreset) memory array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_s && acc_be_s[i]) begin
                mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
            end
        end
    end

    // Request/wait/response sequencing with registered response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_write_r <= 1'b0;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {DAT_WIDTH{1'b0}};
            req_be_r    <= 4'b0000;
            rsp_rdata_r <= {DAT_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_write_r <= req_write;
                        req_addr_r  <= req_addr;
                        req_wdata_r <= req_wdata;
                        req_be_r    <= req_be;
                        cnt_r       <= WAIT_INIT;
                        if (acc_go_s) begin
                            state_r     <= ST_RESP;
                            rsp_rdata_r <= acc_rdata_s;
                            rsp_err_r   <= acc_err_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (acc_go_s) begin
                        state_r     <= ST_RESP;
                        rsp_rdata_r <= acc_rdata_s;
                        rsp_err_r   <= acc_err_s;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_rdata_r <= {DAT_WIDTH{1'b0}};
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
